// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and the step-counter width helper.
package seq_div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS    = 3'd1,
    DIVIDE = 3'd2,
    FIXUP  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference only when it did not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // rem_in < divisor <= 2^(WIDTH-1), so the shifted value fits in WIDTH bits
  // and the top bit of the WIDTH+1 bit difference is exactly the borrow.
  assign trial   = {rem_in, dvd_bit} - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], dvd_bit};

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed divider (truncate toward zero), one restoring step per cycle.
// Optional SEQ_DIV_EARLY_EXIT_EN: skip DIVIDE when |a| < |b|.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rem;
  logic             sign_a;
  logic             sign_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // Negating MIN yields 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign a_mag = sign_a ? -a_cap : a_cap;
  assign b_mag = b_cap[WIDTH-1] ? -b_cap : b_cap;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (b_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      z           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      a_cap       <= '0;
      b_cap       <= '0;
      dvd         <= '0;
      q           <= '0;
      rem         <= '0;
      sign_a      <= 1'b0;
      sign_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_cap    <= a;
            b_cap    <= b;
            sign_a   <= a[WIDTH-1];
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            in_ready <= 1'b0;
            state    <= ABS;
          end
        end
        ABS: begin
          rem <= '0;
          q   <= '0;
          dvd <= a_mag;
          cnt <= CW'(WIDTH - 1);
          if (b_cap == '0) begin
            z           <= '1;
            r           <= a_cap;
            div_by_zero <= 1'b1;
            out_valid   <= 1'b1;
            state       <= DONE;
`ifdef SEQ_DIV_EARLY_EXIT_EN
          end else if (a_mag < b_mag) begin
            rem   <= a_mag;
            state <= FIXUP;
`endif
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem <= step_rem;
          q   <= {q[WIDTH-2:0], step_q};
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          z           <= sign_q ? -q : q;
          r           <= sign_a ? -rem : rem;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Randomized self-checking bench for seq_div against a plain-arithmetic model.
module tb_seq_div;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] z;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [W-1:0] z;
  logic [W-1:0] r;
  logic         dbz;
  logic         out_valid;

  int   total = 0;
  int   bad = 0;
  res_t exp_q[$];

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .z           (z),
    .r           (r),
    .div_by_zero (dbz),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SV '/' and '%' truncate toward zero with the remainder taking the dividend's sign;
  // MIN / -1 overflows to 2^(W-1), which truncates back to MIN.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    res_t   m;
    longint sa, sb, qq, rr;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (mb == '0) begin
      m.z = '1; m.r = ma; m.dbz = 1'b1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      m.z = qq[W-1:0]; m.r = rr[W-1:0]; m.dbz = 1'b0;
    end
    return m;
  endfunction

  // Edges after the accepting edge until out_valid is seen high.
  function automatic int exp_lat(input logic [W-1:0] la, input logic [W-1:0] lb);
    longint sa, sb;
    sa = longint'($signed(la));
    sb = longint'($signed(lb));
    if (lb == '0) return 1;
`ifdef SEQ_DIV_EARLY_EXIT_EN
    if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) return 2;
`endif
    return W + 2;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("model_z", 64'(z), 64'(exp_q[0].z));
        chk("model_r", 64'(r), 64'(exp_q[0].r));
        chk("model_dbz", 64'(dbz), 64'(exp_q[0].dbz));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int hold,
                        input bit early_rdy, input bit lit,
                        input logic [W-1:0] ez, input logic [W-1:0] er, input logic edbz);
    int waitc = 0;
    int lat = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", 64'd0, 64'd1);
      return;
    end
    a = ta; b = tb_; in_valid = 1'b1; out_ready = early_rdy;
    @(posedge clk);
    exp_q.push_back(model(ta, tb_));
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat(ta, tb_)));
    if (lit) begin
      chk("lit_z", 64'(z), 64'(ez));
      chk("lit_r", 64'(r), 64'(er));
      chk("lit_dbz", 64'(dbz), 64'(edbz));
    end
    if (!early_rdy) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int waitc;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Hand-computed cases pinning both the DUT and the model.
    run_op(32'd100, 32'd7, 0, 1'b1, 1'b1, 32'd14, 32'd2, 1'b0);
    run_op(-32'sd100, 32'd7, 0, 1'b0, 1'b1, -32'sd14, -32'sd2, 1'b0);
    run_op(32'd100, -32'sd7, 0, 1'b0, 1'b1, -32'sd14, 32'd2, 1'b0);
    run_op(-32'sd100, -32'sd7, 0, 1'b0, 1'b1, 32'd14, -32'sd2, 1'b0);
    run_op(32'h12345678, 32'd0, 0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    run_op(32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 1'b1, 32'h80000000, 32'd0, 1'b0);
    run_op(32'd5, 32'd9, 0, 1'b0, 1'b1, 32'd0, 32'd5, 1'b0);
    run_op(-32'sd5, 32'd9, 0, 1'b0, 1'b1, 32'd0, -32'sd5, 1'b0);
    run_op(32'd1000, 32'd33, 10, 1'b0, 1'b1, 32'd30, 32'd10, 1'b0);

    // Reset pulse ten cycles into DIVIDE: operation is dropped.
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    a = 32'd123456; b = 32'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_z", 64'(z), 64'd0);
    chk("mid_rst_r", 64'(r), 64'd0);
    chk("mid_rst_dbz", 64'(dbz), 64'd0);
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
    end
    run_op(32'd9, 32'd3, 0, 1'b0, 1'b1, 32'd3, 32'd0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h80000000;
        1:       ra = 32'($urandom_range(0, 30));
        2:       ra = -32'($urandom_range(0, 30));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'b0, '0, '0, 1'b0);
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
